// File: rtl/avalon_st_sink.sv
// avalon_st_sink
//   Receiving end of an 8-bit valid/ready Avalon-ST stream. Drives a registered
//   ready with a ready latency of 0 or 1 cycles, buffers accepted beats in a
//   small circular FIFO and presents them in order on a show-ahead valid/ready
//   port. Counts accepted beats and flags source protocol violations.
//
// Ports
//   clk          in   1        single clock, posedge
//   resetn       in   1        asynchronous active-low reset
//   valid        in   1        source beat valid
//   ready        out  1        sink may accept (registered)
//   data         in   8        source beat data
//   out_valid    out  1        FIFO not empty
//   out_ready    in   1        downstream pops head when out_valid & out_ready
//   out_data     out  8        FIFO head, 0 while empty
//   beat_count   out  COUNT_W  accepted beats since reset, wraps
//   protocol_err out  1        sticky; valid seen while not permitted
module avalon_st_sink #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned READY_LATENCY = 1,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               valid,
    output logic               ready,
    input  logic [7:0]         data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic [COUNT_W-1:0] beat_count,
    output logic               protocol_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] READY_LVL = CNT_W'(DEPTH - 1 - READY_LATENCY);

    logic               ready_q, ready_d;
    logic               ready_dly_q, ready_dly_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0] beat_count_q, beat_count_d;
    logic               protocol_err_q, protocol_err_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];

    logic permit;
    logic full;
    logic push;
    logic pop;

    always_comb begin
        // Beats are only legal READY_LATENCY cycles after ready was seen high.
        permit      = (READY_LATENCY == 0) ? ready_q : ready_dly_q;
        ready_dly_d = ready_q;
        full        = (count_q == FULL_LVL);
        push        = valid & permit & ~full;
        pop         = (count_q != '0) & out_ready;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = data;
        end

        beat_count_d = beat_count_q + COUNT_W'(push);

        // Any valid that is not accepted is a violation: either not permitted,
        // or permitted into a full FIFO (unreachable while ready is honoured).
        protocol_err_d = protocol_err_q | (valid & ~push);

        // Leave room for beats that may still arrive within the ready latency.
        ready_d = (count_d <= READY_LVL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q        <= 1'b0;
            ready_dly_q    <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            beat_count_q   <= '0;
            protocol_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ready_q        <= ready_d;
            ready_dly_q    <= ready_dly_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            beat_count_q   <= beat_count_d;
            protocol_err_q <= protocol_err_d;
            mem_q          <= mem_d;
        end
    end

    always_comb begin
        ready        = ready_q;
        out_valid    = (count_q != '0);
        out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
        beat_count   = beat_count_q;
        protocol_err = protocol_err_q;
    end

endmodule

// File: tb/tb_avalon_st_sink.sv
// tb_avalon_st_sink
//   Self-checking bench for avalon_st_sink (DEPTH=4, READY_LATENCY=1). A second
//   instance with COUNT_W=4 shares all inputs to observe beat_count wrap.
module tb_avalon_st_sink;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [7:0]  data;
    logic        out_ready;

    logic        ready, out_valid, protocol_err;
    logic [7:0]  out_data;
    logic [15:0] beat_count;

    logic        ready4, out_valid4, protocol_err4;
    logic [7:0]  out_data4;
    logic [3:0]  beat_count4;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  sb_q [$];
    int unsigned sent_cnt;
    logic        prev_ready;
    logic [7:0]  next_data;

    avalon_st_sink #(.DEPTH(4), .READY_LATENCY(1), .COUNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .data(data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_count(beat_count), .protocol_err(protocol_err)
    );

    avalon_st_sink #(.DEPTH(4), .READY_LATENCY(1), .COUNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready4), .data(data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .beat_count(beat_count4), .protocol_err(protocol_err4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        ordy;
        logic        e_ready;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [15:0] e_bc;
        logic        e_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reset held 3 cycles; returns just after release at a negedge (cycle 0).
    task automatic do_reset();
        resetn    = 1'b0;
        valid     = 1'b0;
        data      = 8'h00;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ready_in_reset", ready, 1'b0);
        end
        resetn = 1'b1;
        check("ready_cycle0", ready, 1'b0);
        sb_q.delete();
        sent_cnt   = 0;
        prev_ready = 1'b0;
    endtask

    // One cycle of an RL=1 obeying source plus scoreboard pop on output.
    task automatic cycle_src(input logic send_en, input logic ordy);
        logic rnow;
        @(negedge clk);
        rnow      = ready;
        out_ready = ordy;
        if (out_valid && ordy) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=0x%0h required=none", out_data);
            end else begin
                check("sb_data", out_data, sb_q.pop_front());
            end
        end
        valid = send_en & prev_ready;
        data  = valid ? next_data : 8'h00;
        if (valid) begin
            sb_q.push_back(next_data);
            next_data = next_data + 8'd1;
            sent_cnt++;
        end
        prev_ready = rnow;
    endtask

    initial begin
        // cycle-by-cycle trace from cycle 1 after release: beats 4,5,6 sent one cycle after ready
        vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 1'b0};
        vecs[1] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 1'b0};
        vecs[2] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h04, 16'd1, 1'b0};
        vecs[3] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h05, 16'd2, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 16'd3, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 16'd3, 1'b0};

        // Reset state and basic in-order stream
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), ready, vecs[i].e_ready);
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            check($sformatf("vec%0d_beat_count", i), beat_count, vecs[i].e_bc);
            check($sformatf("vec%0d_protocol_err", i), protocol_err, vecs[i].e_err);
            valid     = vecs[i].v;
            data      = vecs[i].d;
            out_ready = vecs[i].ordy;
        end

        // Fill with out_ready=0: exactly DEPTH beats, then drain
        do_reset();
        next_data = 8'h10;
        for (int i = 0; i < 12; i++) cycle_src(1'b1, 1'b0);
        check("fill_sent", sent_cnt, 32'd4);
        check("fill_ready", ready, 1'b0);
        check("fill_out_valid", out_valid, 1'b1);
        check("fill_head", out_data, 8'h10);
        check("fill_beat_count", beat_count, 16'd4);
        check("fill_err", protocol_err, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle_src(1'b0, 1'b1);
            if (sb_q.size() == 0) break;
        end
        check("drain_left", sb_q.size(), 32'd0);
        cycle_src(1'b0, 1'b1);
        cycle_src(1'b0, 1'b1);
        check("drain_ready", ready, 1'b1);
        check("drain_out_valid", out_valid, 1'b0);

        // Protocol violation: valid while permit is still low
        do_reset();
        @(negedge clk);
        valid     = 1'b1;
        data      = 8'hAA;
        out_ready = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'h00;
        check("viol_err", protocol_err, 1'b1);
        check("viol_beat_count", beat_count, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("viol_out_valid", out_valid, 1'b0);
            check("viol_out_data", out_data, 8'h00);
            check("viol_sticky", protocol_err, 1'b1);
        end

        // Mid-cycle reset with two beats stored
        do_reset();
        next_data = 8'h50;
        for (int i = 0; i < 3; i++) cycle_src(1'b1, 1'b0);
        cycle_src(1'b0, 1'b0);
        check("pre_rst_out_valid", out_valid, 1'b1);
        check("pre_rst_beat_count", beat_count, 16'd2);
        #2 resetn = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_beat_count", beat_count, 16'd0);
        check("rst_ready", ready, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sb_q.delete();
        sent_cnt   = 0;
        prev_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle_src(1'b0, 1'b1);
            check("post_rst_out_valid", out_valid, 1'b0);
        end

        // 17 beats through: 4-bit counter wraps to 1
        do_reset();
        next_data = 8'h80;
        for (int i = 0; i < 80; i++) begin
            cycle_src(sent_cnt < 17, 1'b1);
            if (sent_cnt == 17 && sb_q.size() == 0) break;
        end
        check("wrap_sent", sent_cnt, 32'd17);
        check("wrap_left", sb_q.size(), 32'd0);
        check("wrap_beat_count16", beat_count, 16'd17);
        check("wrap_beat_count4", beat_count4, 4'd1);
        check("wrap_err", protocol_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
